// File: rtl/cpu_bet_executor.sv
// CPU bet executor: waits a think delay, re-validates the suggested action against
// latched stack/bet values, degrades it when illegal, and registers the resulting chips.
module cpu_bet_executor #(
  parameter int BB           = 200,
  parameter int THINK_CYCLES = 3,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  action,
  input  logic [14:0] cpumoney,
  input  logic [14:0] playermoney,
  input  logic [14:0] computerBet,
  input  logic [14:0] playerBet,
  input  logic [15:0] pot_in,
  output logic        busy,
  output logic        done,
  output logic [14:0] cpumoney_out,
  output logic [14:0] computerBet_out,
  output logic [15:0] pot_out,
  output logic [2:0]  applied_action,
  output logic        fold,
  output logic        allin,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, THINK, APPLY, DONE} state_t;

  typedef struct packed {
    logic [2:0]  act;
    logic [14:0] add;
  } res_t;

  localparam logic [2:0]  ACT_CHECK = 3'd0;
  localparam logic [2:0]  ACT_CALL  = 3'd1;
  localparam logic [2:0]  ACT_ALLIN = 3'd5;
  localparam logic [2:0]  ACT_FOLD  = 3'd6;
  localparam logic [14:0] TGT_2BB   = 15'(2 * BB);
  localparam logic [14:0] TGT_4BB   = 15'(4 * BB);
  localparam logic [14:0] TGT_6BB   = 15'(6 * BB);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((THINK_CYCLES > 0) ? (THINK_CYCLES - 1) : 0);
  localparam bit HAS_THINK = (THINK_CYCLES > 0);

  // Call resolution; also the fallback for any raise that fails validation.
  function automatic res_t call_res(input logic [14:0] diff, input logic [14:0] cm);
    res_t r;
    if (diff == 15'd0) begin
      r.act = ACT_CHECK;
      r.add = 15'd0;
    end else if (diff < cm) begin
      r.act = ACT_CALL;
      r.add = diff;
    end else begin
      r.act = ACT_ALLIN;
      r.add = cm;
    end
    return r;
  endfunction

  function automatic res_t resolve(input logic [2:0]  a,
                                   input logic [14:0] cm,
                                   input logic [14:0] pm,
                                   input logic [14:0] cb,
                                   input logic [14:0] pb);
    res_t        r;
    logic [14:0] diff;
    logic [14:0] tgt;
    logic [14:0] radd;
    diff = (pb > cb) ? (pb - cb) : 15'd0;
    tgt  = (a == 3'd2) ? TGT_2BB : ((a == 3'd3) ? TGT_4BB : TGT_6BB);
    radd = tgt - cb;
    r.act = ACT_FOLD;
    r.add = 15'd0;
    case (a)
      3'd0: begin
        if (diff == 15'd0) r.act = ACT_CHECK;
      end
      3'd1: r = call_res(diff, cm);
      3'd2, 3'd3, 3'd4: begin
        if ((pb < tgt) && (cb < tgt) && (radd < cm) && (pm != 15'd0)) begin
          r.act = a;
          r.add = radd;
        end else begin
          r = call_res(diff, cm);
        end
      end
      3'd5: begin
        r.act = ACT_ALLIN;
        r.add = cm;
      end
      default: ;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [2:0]  act_q;
  logic [14:0] cm_q, pm_q, cb_q, pb_q;
  logic [15:0] pot_q;

  logic [14:0] cmo_q, cmo_d;
  logic [14:0] cbo_q, cbo_d;
  logic [15:0] poto_q, poto_d;
  logic [2:0]  app_q, app_d;
  logic        fold_q, fold_d;
  logic        allin_q, allin_d;
  logic        err_q, err_d;
  res_t        res;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (HAS_THINK) begin
            state_d = THINK;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = APPLY;
          end
        end
      end
      THINK: begin
        if (cnt_q == '0) state_d = APPLY;
        else             cnt_d   = cnt_q - 1'b1;
      end
      APPLY:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res     = resolve(act_q, cm_q, pm_q, cb_q, pb_q);
    cmo_d   = cm_q - res.add;
    cbo_d   = cb_q + res.add;
    poto_d  = pot_q + {1'b0, res.add};
    app_d   = res.act;
    fold_d  = (res.act == ACT_FOLD);
    allin_d = (cmo_d == 15'd0) && (res.add != 15'd0);
    err_d   = (res.act != act_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmo_q   <= '0;
      cbo_q   <= '0;
      poto_q  <= '0;
      app_q   <= '0;
      fold_q  <= 1'b0;
      allin_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == APPLY) begin
        cmo_q   <= cmo_d;
        cbo_q   <= cbo_d;
        poto_q  <= poto_d;
        app_q   <= app_d;
        fold_q  <= fold_d;
        allin_q <= allin_d;
        err_q   <= err_d;
      end
    end
  end

  // Operand snapshot: only taken when a request is accepted from IDLE.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && start) begin
      act_q <= action;
      cm_q  <= cpumoney;
      pm_q  <= playermoney;
      cb_q  <= computerBet;
      pb_q  <= playerBet;
      pot_q <= pot_in;
    end
  end

  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign cpumoney_out    = cmo_q;
  assign computerBet_out = cbo_q;
  assign pot_out         = poto_q;
  assign applied_action  = app_q;
  assign fold            = fold_q;
  assign allin           = allin_q;
  assign err             = err_q;

endmodule

// File: tb/tb_cpu_bet_executor.sv
// Bench for cpu_bet_executor: directed poker scenarios plus randomized actions,
// checked against a rule-level reference model, on a 3-cycle and a 0-cycle think instance.
module tb_cpu_bet_executor;

  localparam int BB = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        start3, start0;
  logic [2:0]  action;
  logic [14:0] cpumoney, playermoney, computerBet, playerBet;
  logic [15:0] pot_in;

  logic        busy3, done3, fold3, allin3, err3;
  logic [14:0] cmo3, cbo3;
  logic [15:0] pot3;
  logic [2:0]  app3;
  logic        busy0, done0, fold0, allin0, err0;
  logic [14:0] cmo0, cbo0;
  logic [15:0] pot0;
  logic [2:0]  app0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cpu_bet_executor #(.BB(BB), .THINK_CYCLES(3), .CNT_W(8)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .action(action),
    .cpumoney(cpumoney), .playermoney(playermoney), .computerBet(computerBet),
    .playerBet(playerBet), .pot_in(pot_in), .busy(busy3), .done(done3),
    .cpumoney_out(cmo3), .computerBet_out(cbo3), .pot_out(pot3),
    .applied_action(app3), .fold(fold3), .allin(allin3), .err(err3)
  );

  cpu_bet_executor #(.BB(BB), .THINK_CYCLES(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .action(action),
    .cpumoney(cpumoney), .playermoney(playermoney), .computerBet(computerBet),
    .playerBet(playerBet), .pot_in(pot_in), .busy(busy0), .done(done0),
    .cpumoney_out(cmo0), .computerBet_out(cbo0), .pot_out(pot0),
    .applied_action(app0), .fold(fold0), .allin(allin0), .err(err0)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Poker rules straight from the action table, in plain integers.
  task automatic model(input int a, input int cm, input int pm, input int cb,
                       input int pb, output int app, output int add);
    int owed, target;
    owed = (pb > cb) ? pb - cb : 0;
    app = 6;
    add = 0;
    if (a >= 2 && a <= 4) begin
      target = 2 * (a - 1) * BB;
      if (pb < target && cb < target && target - cb < cm && pm != 0) begin
        app = a;
        add = target - cb;
        return;
      end
    end
    if (a >= 1 && a <= 4) begin
      if (owed == 0)      app = 0;
      else if (owed < cm) begin app = 1; add = owed; end
      else                begin app = 5; add = cm; end
    end else if (a == 0) begin
      app = (owed == 0) ? 0 : 6;
    end else if (a == 5) begin
      app = 5;
      add = cm;
    end
  endtask

  task automatic xact(input int which, input int a, input int cm, input int pm,
                      input int cb, input int pb, input int pot, input bit disturb);
    int app, add, lat;
    model(a, cm, pm, cb, pb, app, add);
    lat = (which == 0) ? 1 : 4;
    @(negedge clk);
    action = a[2:0]; cpumoney = cm[14:0]; playermoney = pm[14:0];
    computerBet = cb[14:0]; playerBet = pb[14:0]; pot_in = pot[15:0];
    if (which == 0) start0 = 1'b1; else start3 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start3 = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (which == 3) start3 = 1'b0;
      if (k < lat) begin
        chk("busy_think", (which == 0) ? busy0 : busy3, 1);
        chk("done_early", (which == 0) ? done0 : done3, 0);
      end
      if (k == 1 && disturb) begin
        action = ~action; cpumoney = 15'($urandom); playermoney = 15'($urandom);
        computerBet = 15'($urandom); playerBet = 15'($urandom); pot_in = 16'($urandom);
        start3 = 1'b1;
      end
    end
    chk("done", (which == 0) ? done0 : done3, 1);
    chk("busy_done", (which == 0) ? busy0 : busy3, 1);
    chk("cpumoney_out", (which == 0) ? cmo0 : cmo3, cm - add);
    chk("computerBet_out", (which == 0) ? cbo0 : cbo3, cb + add);
    chk("pot_out", (which == 0) ? pot0 : pot3, pot + add);
    chk("applied", (which == 0) ? app0 : app3, app);
    chk("fold", (which == 0) ? fold0 : fold3, int'(app == 6));
    chk("allin", (which == 0) ? allin0 : allin3, int'(cm - add == 0 && add > 0));
    chk("err", (which == 0) ? err0 : err3, int'(app != a));
    @(posedge clk); #1;
    chk("done_pulse", (which == 0) ? done0 : done3, 0);
    chk("busy_idle", (which == 0) ? busy0 : busy3, 0);
    chk("hold_cpumoney", (which == 0) ? cmo0 : cmo3, cm - add);
    chk("hold_pot", (which == 0) ? pot0 : pot3, pot + add);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy3 | busy0, 0);
    chk({tag, "_done"}, done3 | done0, 0);
    chk({tag, "_money"}, int'(cmo3 | cmo0), 0);
    chk({tag, "_bet"}, int'(cbo3 | cbo0), 0);
    chk({tag, "_pot"}, int'(pot3 | pot0), 0);
    chk({tag, "_flags"}, int'({app3, fold3, allin3, err3} | {app0, fold0, allin0, err0}), 0);
  endtask

  initial begin
    int which, a, cm, pm, cb, pb, pot;
    int seen_done;
    reset = 1'b1; start3 = 1'b0; start0 = 1'b0; action = '0;
    cpumoney = '0; playermoney = '0; computerBet = '0; playerBet = '0; pot_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk); reset = 1'b0;

    xact(3, 1, 5000, 3000, 100, 200, 300, 1'b0);
    xact(3, 3, 1000, 3000, 200, 200, 400, 1'b0);
    xact(3, 4, 900, 3000, 200, 400, 600, 1'b0);
    xact(3, 0, 5000, 3000, 200, 400, 600, 1'b0);
    xact(3, 5, 1234, 3000, 0, 0, 200, 1'b0);
    xact(3, 7, 4000, 3000, 100, 100, 200, 1'b0);
    xact(3, 2, 5000, 0, 0, 200, 300, 1'b0);
    xact(3, 1, 150, 3000, 100, 600, 700, 1'b1);
    xact(0, 1, 5000, 3000, 100, 200, 300, 1'b0);
    xact(0, 4, 8000, 3000, 0, 0, 0, 1'b0);

    // Abort in the middle of the think delay.
    @(negedge clk);
    action = 3'd1; cpumoney = 15'd5000; computerBet = 15'd0; playerBet = 15'd400;
    pot_in = 16'd400; start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk_zero("reset_think");
    @(negedge clk); reset = 1'b0;
    seen_done = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done3 || busy3) seen_done = 1;
    end
    chk("no_done_after_abort", seen_done, 0);

    for (int i = 0; i < 48; i++) begin
      which = (i % 4 == 3) ? 0 : 3;
      a   = $urandom_range(0, 7);
      cm  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1300) : $urandom_range(0, 20000);
      pm  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 20000);
      cb  = $urandom_range(0, 1400);
      pb  = ($urandom_range(0, 2) == 0) ? cb : $urandom_range(0, 1400);
      pot = $urandom_range(0, 30000);
      xact(which, a, cm, pm, cb, pb, pot, (which == 3) && (i % 3 == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
